down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
//
// PURPOSE
//   Loadable down counter: the down-counting complement of the free-running up counter.
//   - Counts from a loaded value down to expiry, in one-shot or auto-reload mode.
//   - Raises a one-cycle terminal-count pulse (tc) on each expiry.
//   - Used as a programmable interval timer / event-delay generator beside the up counters.
//
// PARAMETERS
//   WIDTH   4   width of count, load_value and reload register (WIDTH >= 2)
//
// PORTS
//   clk         in   1      rising-edge clock
//   clear_n     in   1      asynchronous, active-low reset
//   load        in   1      sync load strobe: capture load_value and mode, start run
//   load_value  in   WIDTH  start/reload value; 0 = do not run
//   mode        in   1      0 = one-shot, 1 = auto-reload (sampled only on load)
//   enable      in   1      count-enable; low freezes count in RUN
//   count       out  WIDTH  current counter value (registered)
//   busy        out  1      high while state == RUN (registered)
//   tc          out  1      one-cycle terminal-count pulse (registered)
//
// BEHAVIOUR
//   Reset (clear_n low, async, overrides everything):
//   - state = IDLE; count, reload_reg, mode_reg = 0; busy = 0; tc = 0.
//   States: IDLE, RUN, EXPIRED. busy = (state == RUN).
//   Load (any state, highest sync priority):
//   - reload_reg <= load_value; mode_reg <= mode; count <= load_value; tc <= 0.
//   - load_value != 0 -> RUN; load_value == 0 -> IDLE.
//   RUN, enable = 1, no load:
//   - count > 1: count <= count - 1; tc <= 0.
//   - count == 1, mode_reg = 0: count <= 0; tc <= 1; state -> EXPIRED.
//   - count == 1, mode_reg = 1: count <= reload_reg; tc <= 1; stay in RUN.
//   RUN, enable = 0: count holds; tc <= 0.
//   IDLE / EXPIRED: count holds; tc <= 0; only load leaves these states.
//   enable is ignored outside RUN.
//   Timing:
//   - From load of N (enable held high), tc is high in the cycle count first shows
//     0 (one-shot) or N again (auto-reload).
//   - This is exactly N enabled cycles after the load edge; auto-reload period = N.
//   Corner cases:
//   - Load in the same cycle as expiry: load wins; no tc; count = new load_value.
//   - No underflow: count never wraps below 0; EXPIRED holds 0.
//   - Load of 2**WIDTH-1 is legal; arithmetic is unsigned, WIDTH bits.
//   - clear_n asserted mid-run: outputs go to reset values immediately, without
//     waiting for a clk edge.
//   - clear_n release: first active edge is the first clk rising edge with clear_n high.
//
// TESTING
//   1. One-shot, load 5, enable = 1 -> count 5,4,3,2,1,0; tc = 1 only in the count = 0
//      cycle; busy falls that cycle; count stays 0.
//   2. Auto-reload, load 3, enable = 1 -> count 3,2,1,3,2,1,...; tc = 1 on each return
//      to 3; busy stays 1.
//   3. Load 4, toggle enable 1,0,0,1 -> count 4,3,3,3,2; no tc.
//   4. Auto-reload, count = 1, enable = 1, load 7 in the same cycle -> count 7,
//      tc = 0, mode updated.
//   5. Load 0 -> IDLE, busy 0, tc 0. WIDTH = 4 one-shot load 15 -> tc after
//      exactly 15 enabled cycles.
//   6. clear_n low mid-run (count = 9) -> count 0, busy 0, tc 0 before the next
//      edge; no activity until load.

Source files
------------

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter / interval timer.
// Counts a loaded value down to expiry in one-shot or auto-reload mode and
// raises a one-cycle terminal-count pulse (tc) on every expiry.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state,      state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             mode_reg,   mode_next;
    logic             tc_next;
    logic             busy_next;

    // Next-state and next-output logic: load has priority, then counting in RUN.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        tc_next     = 1'b0;

        if (load) begin
            reload_next = load_value;
            mode_next   = mode;
            count_next  = load_value;
            // A zero load means "do not run": park in IDLE.
            state_next  = (load_value != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        if (count == ONE) begin
                            tc_next = 1'b1;
                            if (mode_reg) begin
                                // Auto-reload: period is exactly reload_reg cycles.
                                count_next = reload_reg;
                            end else begin
                                count_next = '0;
                                state_next = EXPIRED;
                            end
                        end else begin
                            count_next = count - ONE;
                        end
                    end
                end
                // IDLE and EXPIRED hold everything; only load leaves them.
                default: ;
            endcase
        end

        // busy is registered, so it is computed from the state being entered.
        busy_next = (state_next == RUN);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            busy       <= 1'b0;
            tc         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // pre-edge values, matching real flip-flop behaviour.
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            mode_reg   <= mode_next;
            busy       <= busy_next;
            tc         <= tc_next;
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the down counter.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clear_n;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             mode;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .enable     (enable),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. IDLE and EXPIRED look identical from outside (not busy,
    // count frozen), so the model only tracks whether the timer is running.
    int m_count;
    int m_reload;
    bit m_auto;
    bit m_running;
    bit m_tc;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_count   <= 0;
            m_reload  <= 0;
            m_auto    <= 1'b0;
            m_running <= 1'b0;
            m_tc      <= 1'b0;
        end else if (load) begin
            m_count   <= int'(load_value);
            m_reload  <= int'(load_value);
            m_auto    <= mode;
            m_running <= (load_value != 0);
            m_tc      <= 1'b0;
        end else if (m_running && enable) begin
            if (m_count == 1) begin
                m_tc      <= 1'b1;
                m_count   <= m_auto ? m_reload : 0;
                m_running <= m_auto;
            end else begin
                m_count   <= m_count - 1;
                m_tc      <= 1'b0;
            end
        end else begin
            m_tc <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_count", 32'(count), 32'(m_count));
            check("model_busy",  32'(busy),  32'(m_running));
            check("model_tc",    32'(tc),    32'(m_tc));
        end
    end

    // Drive one cycle of inputs, then return just after the following falling edge.
    task automatic cyc(input bit ld, input int lv, input bit md, input bit en);
        load       = ld;
        load_value = WIDTH'(lv);
        mode       = md;
        enable     = en;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int c, input bit b, input bit t);
        check({name, "_count"}, 32'(count), 32'(c));
        check({name, "_busy"},  32'(busy),  32'(b));
        check({name, "_tc"},    32'(tc),    32'(t));
    endtask

    initial begin
        int seq2[6];
        int tc_at;

        clear_n    = 1'b0;
        load       = 1'b0;
        load_value = '0;
        mode       = 1'b0;
        enable     = 1'b0;
        #23;
        expect_out("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        clear_n = 1'b1;
        cmp_en  = 1'b1;

        // 1. One-shot load 5.
        cyc(1, 5, 0, 1);
        expect_out("os_load", 5, 1'b1, 1'b0);
        for (int k = 4; k >= 1; k--) begin
            cyc(0, 0, 0, 1);
            expect_out("os_run", k, 1'b1, 1'b0);
        end
        cyc(0, 0, 0, 1);
        expect_out("os_expire", 0, 1'b0, 1'b1);
        cyc(0, 0, 0, 1);
        expect_out("os_hold", 0, 1'b0, 1'b0);

        // 2. Auto-reload load 3.
        seq2 = '{2, 1, 3, 2, 1, 3};
        cyc(1, 3, 1, 1);
        expect_out("ar_load", 3, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 1);
            expect_out("ar_run", seq2[k], 1'b1, seq2[k] == 3);
        end

        // 3. Enable gating.
        cyc(1, 4, 0, 1);
        expect_out("en_load", 4, 1'b1, 1'b0);
        cyc(0, 0, 0, 1);
        expect_out("en_1", 3, 1'b1, 1'b0);
        cyc(0, 0, 0, 0);
        expect_out("en_0a", 3, 1'b1, 1'b0);
        cyc(0, 0, 0, 0);
        expect_out("en_0b", 3, 1'b1, 1'b0);
        cyc(0, 0, 0, 1);
        expect_out("en_1b", 2, 1'b1, 1'b0);

        // 4. Load coinciding with auto-reload expiry; new mode is one-shot.
        cyc(1, 3, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        expect_out("coll_pre", 1, 1'b1, 1'b0);
        cyc(1, 7, 0, 1);
        expect_out("coll_load", 7, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1);
        expect_out("coll_pre_exp", 1, 1'b1, 1'b0);
        cyc(0, 0, 0, 1);
        expect_out("coll_oneshot", 0, 1'b0, 1'b1);

        // 5. Load 0 stays idle; load 15 expires after exactly 15 cycles.
        cyc(1, 0, 1, 1);
        expect_out("zero_load", 0, 1'b0, 1'b0);
        cyc(0, 0, 0, 1);
        expect_out("zero_hold", 0, 1'b0, 1'b0);
        cyc(1, 15, 0, 1);
        expect_out("max_load", 15, 1'b1, 1'b0);
        tc_at = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 0, 0, 1);
            if (tc === 1'b1) begin
                tc_at = k;
                break;
            end
        end
        check("max_tc_cycle", 32'(tc_at), 32'd15);
        check("max_tc_count", 32'(count), 32'd0);

        // 6. Asynchronous clear mid-run at count 9.
        cyc(1, 12, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        expect_out("clr_pre", 9, 1'b1, 1'b0);
        #1;
        clear_n = 1'b0;
        #1;
        expect_out("clr_async", 0, 1'b0, 1'b0);
        cyc(0, 0, 0, 1);
        clear_n = 1'b1;
        cyc(0, 0, 0, 1);
        expect_out("clr_quiet", 0, 1'b0, 1'b0);
        cyc(0, 0, 0, 1);
        expect_out("clr_quiet2", 0, 1'b0, 1'b0);

        // Randomized traffic, checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                clear_n = 1'b0;
                #2;
                clear_n = 1'b1;
            end
            cyc($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
